// File: rtl/bmp_stream_tx.sv
// Streams a BMP image from byte-wide memory to a scheduler slave port,
// packing bytes little-endian into words and stopping at the header's file size.
module bmp_stream_tx #(
    parameter int DATA_BUS_SIZE = 32,
    parameter int ADDR_W        = 20,
    parameter int HDR_BYTES     = 54
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [1:0]               cfg_mode,
    input  logic [7:0]               cfg_data_proc,
    output logic                     mem_rd,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [7:0]               mem_rdata,
    output logic [1:0]               slv_mode,
    output logic                     slv_data_valid,
    output logic [DATA_BUS_SIZE-1:0] slv_data,
    output logic [7:0]               slv_data_proc,
    input  logic                     slv_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int BPW     = DATA_BUS_SIZE / 8;
    localparam int CW      = $clog2(BPW + 1);
    localparam int FS_BASE = (5 / BPW) * BPW;
    localparam logic [32:0] MAX_FS = 33'd1 << ADDR_W;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_SEND  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    logic [2:0]               state;
    logic [CW-1:0]            byte_cnt;
    logic [32:0]              base;
    logic [31:0]              file_size;
    logic                     fs_known;
    logic                     rd_pend;
    logic [ADDR_W-1:0]        addr_q;
    logic [DATA_BUS_SIZE-1:0] data_q;
    logic [1:0]               mode_q;
    logic [7:0]               proc_q;
    logic                     err_q;

    logic [32:0]   lane_addr;
    logic [32:0]   cap_addr;
    logic [CW-1:0] cap_lane;
    logic          lane_live;
    logic          issue;
    logic          capture;
    logic [7:0]    cap_byte;
    logic [31:0]   fs_next;
    logic          fs_bad;
    logic          last_word;

    // Lanes past the end of the file are only suppressed once the size field is known.
    always_comb begin
        lane_addr = base + 33'(byte_cnt);
        cap_addr  = lane_addr - 33'd1;
        cap_lane  = byte_cnt - CW'(1);
        lane_live = !fs_known || (lane_addr < {1'b0, file_size});
        issue     = (state == S_FETCH) && (byte_cnt < CW'(BPW)) && lane_live;
        capture   = (state == S_FETCH) && (byte_cnt != '0);
        cap_byte  = rd_pend ? mem_rdata : 8'h00;
        fs_next   = file_size;
        for (int i = 0; i < 4; i++) begin
            if (capture && (cap_addr == 33'(i + 2))) begin
                fs_next[8*i +: 8] = cap_byte;
            end
        end
        fs_bad    = ({1'b0, fs_next} < 33'(HDR_BYTES)) || ({1'b0, fs_next} > MAX_FS);
        last_word = fs_known && ((base + 33'(BPW)) >= {1'b0, file_size});
    end

    assign mem_rd         = issue;
    assign mem_addr       = issue ? lane_addr[ADDR_W-1:0] : addr_q;
    assign slv_mode       = mode_q;
    assign slv_data_proc  = proc_q;
    assign slv_data       = data_q;
    assign slv_data_valid = (state == S_SEND);
    assign busy           = (state == S_FETCH) || (state == S_SEND) || (state == S_ERR);
    assign done           = (state == S_DONE);
    assign err            = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            byte_cnt  <= '0;
            base      <= '0;
            file_size <= '0;
            fs_known  <= 1'b0;
            rd_pend   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            mode_q    <= 2'b00;
            proc_q    <= 8'h00;
            err_q     <= 1'b0;
        end else begin
            rd_pend <= issue;
            if (issue) begin
                addr_q <= lane_addr[ADDR_W-1:0];
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if ((cfg_mode == 2'b01) || (cfg_mode == 2'b10)) begin
                            mode_q    <= cfg_mode;
                            proc_q    <= cfg_data_proc;
                            err_q     <= 1'b0;
                            base      <= '0;
                            byte_cnt  <= '0;
                            file_size <= '0;
                            fs_known  <= 1'b0;
                            state     <= S_FETCH;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    if (capture) begin
                        for (int i = 0; i < BPW; i++) begin
                            if (cap_lane == CW'(i)) begin
                                data_q[8*i +: 8] <= cap_byte;
                            end
                        end
                        file_size <= fs_next;
                    end
                    if (byte_cnt == CW'(BPW)) begin
                        byte_cnt <= '0;
                        // The word holding byte 5 completes the size field; validate it here.
                        if (!fs_known && (base == 33'(FS_BASE)) && fs_bad) begin
                            err_q <= 1'b1;
                            state <= S_ERR;
                        end else begin
                            if (base == 33'(FS_BASE)) begin
                                fs_known <= 1'b1;
                            end
                            state <= S_SEND;
                        end
                    end else begin
                        byte_cnt <= byte_cnt + CW'(1);
                    end
                end
                S_SEND: begin
                    if (slv_ready) begin
                        if (last_word) begin
                            mode_q <= 2'b00;
                            proc_q <= 8'h00;
                            state  <= S_DONE;
                        end else begin
                            base  <= base + 33'(BPW);
                            state <= S_FETCH;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bmp_stream_tx.sv
// Directed bench for bmp_stream_tx: memory model, word receiver and scripted transfers.
module tb_bmp_stream_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_data_proc;
    logic        mem_rd;
    logic [19:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic [1:0]  slv_mode;
    logic        slv_data_valid;
    logic [31:0] slv_data;
    logic [7:0]  slv_data_proc;
    logic        slv_ready = 1'b0;
    logic        busy;
    logic        done;
    logic        err;

    logic [7:0]  img [0:255];
    logic [31:0] rx_words [$];

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int ready_mode = 0;
    int rd_cnt, hi_rd_cnt, done_cnt, valid_cnt, attr_bad, hold_seen;
    logic [1:0]  exp_mode = 2'b01;
    logic [7:0]  exp_proc = 8'h80;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data = 32'h0;

    always #5 clk = ~clk;

    bmp_stream_tx #(.DATA_BUS_SIZE(32), .ADDR_W(20), .HDR_BYTES(54)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_mode(cfg_mode),
        .cfg_data_proc(cfg_data_proc), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .slv_mode(slv_mode), .slv_data_valid(slv_data_valid),
        .slv_data(slv_data), .slv_data_proc(slv_data_proc), .slv_ready(slv_ready),
        .busy(busy), .done(done), .err(err)
    );

    // Synchronous byte memory: data appears one cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= img[mem_addr[7:0]];
    end

    task automatic checkOutput(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        checks++;
        if (got_v === exp_v) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    endtask

    // Receiver: drives ready, records accepted words and watches hold/attribute rules.
    always @(negedge clk) begin
        cyc++;
        slv_ready = (ready_mode == 0) ? 1'b1 : ((ready_mode == 1) ? ((cyc % 3) == 0) : 1'b0);
        if (mem_rd) begin
            rd_cnt++;
            if (mem_addr >= 20'd58) hi_rd_cnt++;
        end
        if (done) done_cnt++;
        if (busy && (slv_mode != exp_mode)) attr_bad++;
        if (slv_data_valid) begin
            valid_cnt++;
            if ((slv_mode != exp_mode) || (slv_data_proc != exp_proc)) attr_bad++;
            if (prev_hold) begin
                hold_seen++;
                checkOutput("hold_stable", slv_data, prev_data);
            end
            if (slv_ready) rx_words.push_back(slv_data);
        end
        prev_hold = slv_data_valid && !slv_ready;
        prev_data = slv_data;
    end

    function automatic logic [31:0] expWord(input int w);
        logic [31:0] r;
        r = 32'h0;
        for (int k = 0; k < 4; k++) begin
            if ((4 * w + k) < 58) r[8*k +: 8] = img[4 * w + k];
        end
        return r;
    endfunction

    task automatic clearStats();
        rx_words.delete();
        rd_cnt = 0; hi_rd_cnt = 0; done_cnt = 0; valid_cnt = 0; attr_bad = 0; hold_seen = 0;
    endtask

    task automatic applyStimulus(input logic [1:0] mode, input logic [7:0] proc);
        @(negedge clk);
        cfg_mode = mode;
        cfg_data_proc = proc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitEnd(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done || err) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic checkWords(input string tag);
        logic [31:0] w0, w14;
        checkOutput({tag, "_count"}, 64'(rx_words.size()), 64'd15);
        for (int i = 0; i < rx_words.size() && i < 15; i++)
            checkOutput($sformatf("%s_word%0d", tag, i), rx_words[i], expWord(i));
        w0  = (rx_words.size() > 0)  ? rx_words[0]  : 32'hFFFF_FFFF;
        w14 = (rx_words.size() > 14) ? rx_words[14] : 32'hFFFF_FFFF;
        checkOutput({tag, "_word0_lit"}, w0, 32'h003A4D42);
        checkOutput({tag, "_word14_lit"}, w14, 32'h00004948);
        checkOutput({tag, "_tail_reads"}, 64'(hi_rd_cnt), 64'd0);
        checkOutput({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        checkOutput({tag, "_attr_bad"}, 64'(attr_bad), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        cfg_mode = 2'b00;
        cfg_data_proc = 8'h00;
        for (int i = 0; i < 256; i++) img[i] = (i < 58) ? 8'(i + 16) : 8'hEE;
        img[0] = 8'h42; img[1] = 8'h4D; img[2] = 8'h3A;
        img[3] = 8'h00; img[4] = 8'h00; img[5] = 8'h00;
        clearStats();

        repeat (2) @(negedge clk);
        checkOutput("reset_ctrl", {mem_rd, mem_addr, slv_mode, slv_data_valid, slv_data_proc, busy, done, err}, 64'd0);
        checkOutput("reset_data", slv_data, 32'h0);
        rst_n = 1'b1;

        // Good image, ready always high, with first-word latency checks
        ready_mode = 0;
        clearStats();
        applyStimulus(2'b01, 8'h80);
        checkOutput("t1_first_read", {busy, mem_rd, mem_addr}, {1'b1, 1'b1, 20'd0});
        repeat (4) @(negedge clk);
        checkOutput("t1_valid_early", slv_data_valid, 1'b0);
        @(negedge clk);
        checkOutput("t1_valid_rise", slv_data_valid, 1'b1);
        waitEnd("t1");
        checkOutput("t1_done_state", {done, busy, slv_mode, slv_data_proc}, {1'b1, 1'b0, 2'b00, 8'h00});
        repeat (5) @(negedge clk);
        checkWords("t1");

        // Same image under 1-of-3 ready backpressure
        ready_mode = 1;
        clearStats();
        applyStimulus(2'b01, 8'h80);
        waitEnd("t2");
        repeat (5) @(negedge clk);
        checkWords("t2");
        checkOutput("t2_holds_seen", 64'(hold_seen > 0), 64'd1);

        // Undersized file-size field
        ready_mode = 0;
        img[2] = 8'h28;
        clearStats();
        applyStimulus(2'b01, 8'h80);
        waitEnd("t3");
        checkOutput("t3_err_state", {err, busy}, 2'b11);
        repeat (5) @(negedge clk);
        checkOutput("t3_words", 64'(rx_words.size()), 64'd1);
        checkOutput("t3_word0", (rx_words.size() > 0) ? rx_words[0] : 32'hFFFF_FFFF, 32'h00284D42);
        checkOutput("t3_valid_cycles", 64'(valid_cnt), 64'd1);
        checkOutput("t3_no_done", 64'(done_cnt), 64'd0);
        checkOutput("t3_err_sticky", {err, busy}, 2'b10);
        img[2] = 8'h3A;
        clearStats();
        applyStimulus(2'b01, 8'h80);
        checkOutput("t3_err_cleared", err, 1'b0);
        waitEnd("t3b");
        repeat (5) @(negedge clk);
        checkWords("t3b");

        // Illegal mode
        clearStats();
        applyStimulus(2'b11, 8'h55);
        checkOutput("t4_err_idle", {err, busy}, 2'b10);
        repeat (10) @(negedge clk);
        checkOutput("t4_no_activity", {32'(rd_cnt), 32'(valid_cnt)}, 64'd0);

        // Reset during the word 7 SEND cycle
        clearStats();
        applyStimulus(2'b01, 8'h80);
        repeat (47) @(negedge clk);
        checkOutput("t5_word7_valid", {slv_data_valid, slv_data}, {1'b1, expWord(7)});
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5_reset_ctrl", {mem_rd, mem_addr, slv_mode, slv_data_valid, slv_data_proc, busy, done, err}, 64'd0);
        checkOutput("t5_reset_data", slv_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        clearStats();
        applyStimulus(2'b01, 8'h80);
        waitEnd("t5");
        repeat (5) @(negedge clk);
        checkWords("t5");

        // Start pulses while busy must be ignored
        clearStats();
        applyStimulus(2'b01, 8'h80);
        repeat (10) @(negedge clk);
        cfg_mode = 2'b10; cfg_data_proc = 8'h11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitEnd("t6");
        repeat (10) @(negedge clk);
        checkWords("t6");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/bmp_stream_tx.md
# bmp_stream_tx

Source-side transmitter for the image-processing slave interface. It reads a BMP file byte-by-byte from a synchronous byte-wide memory and packs the bytes little-endian into DATA_BUS_SIZE words. It streams those words to the scheduler's slave port (mode, data_valid, data, data_proc, with ready backpressure) and uses the BMP header's file-size field to decide how many words to send. Each instance drives one slave port (slv0 or slv1) of the scheduler; test benches and the SoC loader both use it.

## Interface
- DATA_BUS_SIZE, 32, slave data width in bits; multiple of 8; BPW = DATA_BUS_SIZE/8 bytes per word
- ADDR_W, 20, byte address width of source memory
- HDR_BYTES, 54, minimum legal file size (BMP header length)

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin transfer; sampled only in IDLE
- cfg_mode  in  2  processing mode for this transfer; legal values 01, 10
- cfg_data_proc  in  8  processing parameter for this transfer
- mem_rd  out  1  memory read strobe
- mem_addr  out  ADDR_W  byte address
- mem_rdata  in  8  read data, valid exactly 1 cycle after mem_rd
- slv_mode  out  2  to scheduler slvN_mode
- slv_data_valid  out  1  to scheduler slvN_data_valid
- slv_data  out  DATA_BUS_SIZE  to scheduler slvN_data; byte k at bits [8k+7:8k]
- slv_data_proc  out  8  to scheduler slvN_data_proc
- slv_ready  in  1  scheduler accepts the word
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse after final word accepted
- err  out  1  sticky error; cleared by the next accepted start

## Operation
- Reset values: mem_rd=0, mem_addr=0, slv_mode=00, slv_data_valid=0, slv_data=0, slv_data_proc=0, busy=0, done=0, err=0; FSM=IDLE; word/byte counters=0.
- FSM states: IDLE, FETCH, SEND, DONE, ERR.
- IDLE: on start=1 with cfg_mode of 01 or 10, latch cfg_mode/cfg_data_proc onto slv_mode/slv_data_proc, clear err and go to FETCH.
  - start=1 with cfg_mode 00 or 11: set err=1 and stay in IDLE.
- FETCH:
  - Issue BPW reads on consecutive cycles at addresses BPW*w .. BPW*w+BPW-1.
  - Capture each returned byte into its lane.
  - Lanes whose address is >= file_size (once file_size is known) are forced to 0x00 and no read is issued; mem_rd stays low for those cycles.
  - After the last capture, go to SEND.
- SEND:
  - slv_data_valid=1; slv_data, slv_mode and slv_data_proc are held stable until slv_ready=1 at a rising edge.
  - After the handshake: if w == total_words-1, go to DONE; otherwise increment w and go to FETCH.
- file_size = {byte5,byte4,byte3,byte2}, 32-bit, captured as the bytes arrive.
  - Checked at the end of the FETCH that completes byte 5.
  - If file_size < HDR_BYTES or file_size > 2^ADDR_W: go to ERR.
- total_words = (file_size + BPW - 1) / BPW, computed in 33-bit arithmetic (no overflow).
- ERR: err=1, slv_data_valid=0; the unsent word is discarded. Return to IDLE next cycle.
- DONE: done=1 for one cycle; slv_mode=00 and slv_data_proc=0; return to IDLE.
- busy=1 in FETCH, SEND and ERR.
- start while busy is ignored.
- Async reset at any point returns every output to its reset value immediately; a partial transfer is abandoned, not resumed.

## Timing
- start sampled at edge E0: reads are presented in cycles E0–E1 .. E(BPW-1)–E(BPW); bytes are captured at E2..E(BPW+1).
  - slv_data_valid rises after E(BPW+1), i.e. 5 cycles after start for BPW=4.
- With slv_ready held high: one word every BPW+2 cycles (BPW issue cycles, 1 drain cycle, 1 SEND cycle).
- slv_ready is sampled only in SEND. Ready asserted early has no effect; valid never waits on ready.
- done rises in the cycle after the final handshake edge; busy falls in the same cycle.
- mem_addr holds its last value when mem_rd=0.

## Test plan
- Image of 58 bytes (bytes 2..5 = 3A 00 00 00), cfg_mode=01, cfg_data_proc=0x80, ready tied high:
  - 15 words sent; word0 = {b3,b2,b1,b0}; word14 = {00,00,b57,b56}; no reads at addresses 58/59.
  - done pulses once; slv_mode stays 01 throughout.
- Same image, slv_ready toggling 1-of-3 cycles: identical word sequence; each word held stable while valid && !ready.
- file_size field = 40: word0 and word1 are fetched, word0 is sent, then err=1.
  - Word1 is never valid; no done pulse; next start with a good image clears err.
- cfg_mode=11 with start: err=1, busy stays 0, no mem_rd, no valid.
- rst_n low in the middle of word 7 SEND: all outputs at reset values the same cycle.
  - After release, a new start transmits the image from word 0.
- start re-asserted during a transfer: ignored; word count and done are unchanged.
